line_render_scheduler: RTL

- Per-scanline scheduler for the shared layer renderer.
- On each horizontal-blank start it swaps the ping-pong line buffers and latches the upcoming render line from the video timer's vrender.
- It then launches one render job per enabled layer, in order, over a start/done handshake with the single renderer.
- It detects and counts jobs that overrun the line period, aborting them cleanly.

---
 rtl/line_render_scheduler_if.sv | 21 ++
 rtl/line_render_scheduler.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/line_render_scheduler_if.sv
// Job handshake between the line scheduler and the shared layer renderer.
interface line_render_scheduler_if #(
  parameter int unsigned LW = 2
);
  logic          rd_start;
  logic [LW-1:0] rd_layer;
  logic [8:0]    rd_line;
  logic          rd_buf;
  logic          rd_abort;
  logic          rd_done;

  modport master (
    output rd_start, rd_layer, rd_line, rd_buf, rd_abort,
    input  rd_done
  );

  modport slave (
    input  rd_start, rd_layer, rd_line, rd_buf, rd_abort,
    output rd_done
  );
endinterface

// File: rtl/line_render_scheduler.sv
// Per-scanline scheduler: swaps ping-pong line buffers at each line boundary,
// launches one render job per enabled layer in ascending order, and aborts and
// counts lines whose jobs are still outstanding when the next line begins.
module line_render_scheduler #(
  parameter int unsigned LAYERS  = 4,
  parameter int unsigned VACTIVE = 240,
  parameter int unsigned CNTW    = 8,
  localparam int unsigned LW     = (LAYERS > 1) ? $clog2(LAYERS) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          lhbl,
  input  logic                          lvbl,
  input  logic [8:0]                    vrender,
  input  logic [LAYERS-1:0]             layer_en,
  input  logic                          clr_on_frame,
  line_render_scheduler_if.master       rd,
  output logic                          wr_sel,
  output logic                          rd_sel,
  output logic                          busy,
  output logic                          line_ready,
  output logic [CNTW-1:0]               overrun_cnt
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StLaunch = 2'd1;
  localparam logic [1:0] StWait   = 2'd2;

  localparam logic [9:0] VactLim = 10'(VACTIVE);

  logic [1:0]        state_q, state_d;
  logic              lhbl_l_q, lhbl_l_d;
  logic              lvbl_l_q, lvbl_l_d;
  logic              wr_sel_q, wr_sel_d;
  logic [8:0]        line_q, line_d;
  logic [LAYERS-1:0] mask_q, mask_d;
  logic [LW-1:0]     layer_q, layer_d;
  logic              line_ready_q, line_ready_d;
  logic              abort_q, abort_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;

  logic              hb_edge, vb_rise, overrun;
  logic              nxt_found;
  logic [LW-1:0]     nxt_idx, first_idx;
  logic              launch_new;

  // Next-state logic: edge detect, layer sequencing, overrun handling, counter.
  always_comb begin
    lhbl_l_d     = lhbl;
    lvbl_l_d     = lvbl;
    hb_edge      = lhbl_l_q & ~lhbl;
    vb_rise      = ~lvbl_l_q & lvbl;

    state_d      = state_q;
    wr_sel_d     = wr_sel_q;
    line_d       = line_q;
    mask_d       = mask_q;
    layer_d      = layer_q;
    line_ready_d = 1'b0;
    abort_d      = 1'b0;
    cnt_d        = cnt_q;
    overrun      = 1'b0;

    // Lowest enabled layer above the current one, in the latched mask.
    nxt_found = 1'b0;
    nxt_idx   = '0;
    for (int i = LAYERS - 1; i >= 0; i--) begin
      if (mask_q[i] && (i > int'(layer_q))) begin
        nxt_found = 1'b1;
        nxt_idx   = LW'(i);
      end
    end

    // Lowest enabled layer of the incoming mask, for a fresh line.
    first_idx = '0;
    for (int i = LAYERS - 1; i >= 0; i--) begin
      if (layer_en[i]) first_idx = LW'(i);
    end
    launch_new = ({1'b0, vrender} < VactLim) && (layer_en != '0);

    unique case (state_q)
      StLaunch: state_d = StWait;
      StWait: begin
        if (rd.rd_done) begin
          if (nxt_found) begin
            layer_d = nxt_idx;
            state_d = StLaunch;
          end else begin
            line_ready_d = 1'b1;
            state_d      = StIdle;
          end
        end
      end
      default: ;
    endcase

    // Line boundary: a finish landing on this very cycle still counts as done.
    if (hb_edge) begin
      if (state_q != StIdle) begin
        if (!(state_q == StWait && rd.rd_done && !nxt_found)) begin
          abort_d = 1'b1;
          overrun = 1'b1;
        end
      end
      wr_sel_d = ~wr_sel_q;
      line_d   = vrender;
      mask_d   = layer_en;
      state_d  = StIdle;
      if (launch_new) begin
        layer_d = first_idx;
        state_d = StLaunch;
      end
    end

    if (overrun && (cnt_q != {CNTW{1'b1}})) cnt_d = cnt_q + CNTW'(1);
    if (vb_rise && clr_on_frame) cnt_d = '0;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      lhbl_l_q     <= 1'b0;
      lvbl_l_q     <= 1'b0;
      wr_sel_q     <= 1'b0;
      line_q       <= '0;
      mask_q       <= '0;
      layer_q      <= '0;
      line_ready_q <= 1'b0;
      abort_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      lhbl_l_q     <= lhbl_l_d;
      lvbl_l_q     <= lvbl_l_d;
      wr_sel_q     <= wr_sel_d;
      line_q       <= line_d;
      mask_q       <= mask_d;
      layer_q      <= layer_d;
      line_ready_q <= line_ready_d;
      abort_q      <= abort_d;
      cnt_q        <= cnt_d;
    end
  end

  assign rd.rd_start  = (state_q == StLaunch);
  assign rd.rd_layer  = layer_q;
  assign rd.rd_line   = line_q;
  assign rd.rd_buf    = wr_sel_q;
  assign rd.rd_abort  = abort_q;
  assign wr_sel       = wr_sel_q;
  assign rd_sel       = ~wr_sel_q;
  assign busy         = (state_q != StIdle);
  assign line_ready   = line_ready_q;
  assign overrun_cnt  = cnt_q;

endmodule
